mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers for the P6 pipeline.
- Consumes the mult, multu, div, divu, mthi and mtlo decode signals, carried to E stage as an encoded opcode.
- Models fixed multi-cycle latency with a busy flag, which the hazard unit uses to stall HI/LO-class instructions in D.
- Supplies HI/LO values to the mfhi/mflo E-stage result mux.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd/maddu when enabled); legal range 1–15.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1–15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- md_op  in  4  E-stage operation code; MD_NONE when no MDU instruction is in E.
- rs_data  in  32  forwarded rs operand.
- rt_data  in  32  forwarded rt operand.
- busy  out  1  operation in flight (registered).
- stall_req  out  1  busy OR md_op is a mult/div/madd class op; to hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, counter=0, pending result=0; any in-flight operation is discarded.
- Operation accept at edge T, when busy=0 and md_op is a mult/div class op:
  - Latch the 64-bit result into pending {p_hi,p_lo}.
  - Load counter with N = MULT_CYCLES or DIV_CYCLES.
  - busy is high for cycles T+1 through T+N.
  - At the edge ending cycle T+N: {hi,lo} <= {p_hi,p_lo} and busy <= 0. New values are visible in the same cycle busy falls.
- Arithmetic rules:
  - mult: signed 32x32 to 64; hi = upper word, lo = lower word.
  - multu: unsigned 32x32 to 64.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the dividend's sign. Special case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt_data=0): latency runs in full; hi/lo keep their previous values at completion (no update).
- mthi/mtlo, when busy=0: hi (or lo) <= rs_data at edge T, with no busy period.
- Any md_op presented while busy=1 is ignored, including mthi/mtlo. The hazard unit guarantees this does not happen; the unit still must not corrupt state.
- stall_req is combinational: busy | (md_op ∈ {MULT, MULTU, DIV, DIVU, MADD, MADDU}). mthi/mtlo/mfhi/mflo in D stall on stall_req.
- md_op=MD_NONE or any unused code: no state change.
- Counter: 4-bit down-counter, saturates at 0. busy = (counter != 0).

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: opcodes MD_MADD and MD_MADDU are accepted. Pending = {hi,lo} + signed product (madd) or + unsigned product (maddu), modulo 2^64, using the hi/lo values at the accept edge. Latency is MULT_CYCLES.
- Undefined: both codes are treated as MD_NONE, and stall_req excludes them.

Decomposition:
- Package mdu_pkg holds:
  - md_op encoding: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8.
  - A helper that classifies an op as a busy-class op.
  - Default latency constants.
- The E-stage op encoder that converts decode flags into md_op lives in the controller, not here.
- One sub-module is natural: mdu_compute, purely combinational, mapping (md_op, rs_data, rt_data, hi, lo) to {p_hi, p_lo, write_en}.
- The top module keeps the counter, busy flag and HI/LO registers.

Test Plan:
- mult rs=0xFFFFFFFD (-3), rt=5: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_req high in accept cycle.
- multu rs=0xFFFFFFFF, rt=2: hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div rs=0xFFFFFFF9 (-7), rt=2: 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7, rt=0: after 10 cycles hi/lo remain unchanged.
- Busy-phase protection: mthi rs=0x12345678 during busy is ignored. mtlo 0xCAFEBABE with busy=0 gives lo=0xCAFEBABE next cycle.
- Reset mid-op: assert reset during cycle 3 of a div. hi=lo=0 and busy=0 immediately (async); no later update occurs.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu rs=1, rt=1 gives hi=1, lo=0 after 5 cycles. Without the macro, md_op=7 produces no change and stall_req=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding, latencies, op classification.
// MDU_MADD_EN adds madd/maddu to the busy-class ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_busy_op(input logic [3:0] op);
    logic res;
    res = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
    res = res || (op == MD_MADD) || (op == MD_MADDU);
`endif
    return res;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational result generator for mult/div (and madd/maddu under MDU_MADD_EN).
// write_en low means the pending result must not be committed (divide by zero, non-arith op).
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] p_hi,
  output logic [31:0] p_lo,
  output logic        write_en
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] dsor_s;
  logic [31:0] dsor_u;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // Sign-extend to 64 bits so a plain unsigned multiply yields the two's-complement product.
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Magnitude divide then fix signs; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_abs  = rs_data[31] ? (32'd0 - rs_data) : rs_data;
  assign b_abs  = rt_data[31] ? (32'd0 - rt_data) : rt_data;
  assign dsor_s = (b_abs == 32'd0) ? 32'd1 : b_abs;
  assign dsor_u = (rt_data == 32'd0) ? 32'd1 : rt_data;
  assign q_s    = (rs_data[31] ^ rt_data[31]) ? (32'd0 - (a_abs / dsor_s)) : (a_abs / dsor_s);
  assign r_s    = rs_data[31] ? (32'd0 - (a_abs % dsor_s)) : (a_abs % dsor_s);
  assign q_u    = rs_data / dsor_u;
  assign r_u    = rs_data % dsor_u;

`ifndef MDU_MADD_EN
  logic unused_hilo;
  assign unused_hilo = ^{hi, lo};
`endif

  always_comb begin
    p_hi     = 32'd0;
    p_lo     = 32'd0;
    write_en = 1'b0;
    case (md_op)
      MD_MULT: begin
        {p_hi, p_lo} = prod_s;
        write_en     = 1'b1;
      end
      MD_MULTU: begin
        {p_hi, p_lo} = prod_u;
        write_en     = 1'b1;
      end
      MD_DIV: begin
        p_hi     = r_s;
        p_lo     = q_s;
        write_en = (rt_data != 32'd0);
      end
      MD_DIVU: begin
        p_hi     = r_u;
        p_lo     = q_u;
        write_en = (rt_data != 32'd0);
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        {p_hi, p_lo} = {hi, lo} + prod_s;
        write_en     = 1'b1;
      end
      MD_MADDU: begin
        {p_hi, p_lo} = {hi, lo} + prod_u;
        write_en     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency busy counter, stall request.
// MDU_MADD_EN enables madd/maddu accumulate ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [3:0]  cnt;
  logic [31:0] p_hi_q;
  logic [31:0] p_lo_q;
  logic        p_we_q;
  logic [31:0] c_hi;
  logic [31:0] c_lo;
  logic        c_we;

  mdu_compute u_compute (
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi       (hi),
    .lo       (lo),
    .p_hi     (c_hi),
    .p_lo     (c_lo),
    .write_en (c_we)
  );

  assign busy      = (cnt != 4'd0);
  assign stall_req = busy | is_busy_op(md_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 4'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
      p_we_q <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (busy) begin
      // Everything on md_op is ignored while an operation is in flight.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && p_we_q) begin
        hi <= p_hi_q;
        lo <= p_lo_q;
      end
    end else if (is_busy_op(md_op)) begin
      cnt    <= is_div_op(md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      p_hi_q <= c_hi;
      p_lo_q <= c_lo;
      p_we_q <= c_we;
    end else if (md_op == MD_MTHI) begin
      hi <= rs_data;
    end else if (md_op == MD_MTLO) begin
      lo <= rs_data;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard, and hand-written
// sequences for busy-phase protection and asynchronous reset during a divide.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_stall;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } sb_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  sb_t  sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    sb_t e;
    int  n;
    @(negedge clk);
    md_op   = v.op;
    rs_data = v.rs;
    rt_data = v.rt;
    #1;
    chk($sformatf("v%0d stall_req", idx), {31'd0, stall_req}, {31'd0, v.exp_stall});
    sb.push_back('{v.exp_hi, v.exp_lo, v.exp_cyc});
    @(negedge clk);
    md_op = MD_NONE;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk($sformatf("v%0d busy_cycles", idx), n, e.exp_cyc);
    chk($sformatf("v%0d hi", idx), hi, e.exp_hi);
    chk($sformatf("v%0d lo", idx), lo, e.exp_lo);
  endtask

  initial begin
    int n;

    vecs[0]  = '{MD_MTHI,  32'h11111111, 32'h0,        32'h11111111, 32'h00000000, 1'b0, 0};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 5};
    vecs[2]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b1, 5};
    vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 10};
    vecs[4]  = '{MD_DIVU,  32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 10};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 10};
    vecs[6]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b1, 10};
    vecs[7]  = '{MD_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b1, 10};
    vecs[8]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, 5};
    vecs[9]  = '{MD_MTLO,  32'hCAFEBABE, 32'h0,        32'h40000000, 32'hCAFEBABE, 1'b0, 0};
    vecs[10] = '{MD_NONE,  32'hDEADBEEF, 32'h3,        32'h40000000, 32'hCAFEBABE, 1'b0, 0};
    vecs[11] = '{4'd15,    32'hDEADBEEF, 32'h3,        32'h40000000, 32'hCAFEBABE, 1'b0, 0};
    vecs[12] = '{MD_MTHI,  32'h0,        32'h0,        32'h00000000, 32'hCAFEBABE, 1'b0, 0};
    vecs[13] = '{MD_MTLO,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
`ifdef MDU_MADD_EN
    vecs[14] = '{MD_MADDU, 32'h1,        32'h1,        32'h00000001, 32'h00000000, 1'b1, 5};
    vecs[15] = '{MD_MADD,  32'hFFFFFFFF, 32'h1,        32'h00000000, 32'hFFFFFFFF, 1'b1, 5};
`else
    vecs[14] = '{MD_MADDU, 32'h1,        32'h1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
    vecs[15] = '{MD_MADD,  32'hFFFFFFFF, 32'h1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
`endif

    reset   = 1'b1;
    md_op   = MD_NONE;
    rs_data = 32'd0;
    rt_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall_req", {31'd0, stall_req}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // mthi during busy must be ignored; mult 2*3 must still land.
    @(negedge clk);
    md_op = MD_MULT; rs_data = 32'd2; rt_data = 32'd3;
    @(negedge clk);
    md_op = MD_NONE;
    @(negedge clk);
    md_op = MD_MTHI; rs_data = 32'h12345678;
    #1;
    chk("busy-phase stall_req", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    md_op = MD_NONE;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy-phase remaining cycles", n, 3);
    chk("busy-phase hi", hi, 32'd0);
    chk("busy-phase lo", lo, 32'd6);

    // Reset asserted in cycle 3 of a div: clears at once and nothing lands later.
    @(negedge clk);
    md_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd3;
    @(negedge clk);
    md_op = MD_NONE;
    repeat (2) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset hi", hi, 32'd0);
    chk("async reset lo", lo, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post-reset hi", hi, 32'd0);
    chk("post-reset lo", lo, 32'd0);
    chk("post-reset busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
